// File: rtl/mem_ctrl_pkg.sv
// Shared types and RV32I width codes for the data-memory access controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size is the low two funct3 bits.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dm_req_t;

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational lane logic: store byte enables and replication, load shift and extension,
// plus natural-alignment detection for the store-side (issue-time) address.
module dmem_lsu_align
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [1:0]  ld_eff_off;
    logic [31:0] ld_shifted;

    // Low offset bits below the access width are dropped (aligned down).
    always_comb begin
        be         = 4'b1111;
        wdata_rep  = wdata;
        misaligned = 1'b0;
        unique case (st_size)
            SZ_B: begin
                be        = 4'b0001 << st_off;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be         = 4'b0011 << {st_off[1], 1'b0};
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = st_off[0];
            end
            default: begin
                be         = 4'b1111;
                misaligned = |st_off;
            end
        endcase
    end

    always_comb begin
        ld_eff_off = 2'b00;
        unique case (ld_funct3[1:0])
            SZ_B:    ld_eff_off = ld_off;
            SZ_H:    ld_eff_off = {ld_off[1], 1'b0};
            default: ld_eff_off = 2'b00;
        endcase
        ld_shifted = rdata >> {ld_eff_off, 3'b000};
        unique case (ld_funct3)
            F3_B:    rdata_ext = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            F3_H:    rdata_ext = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            F3_BU:   rdata_ext = {24'd0, ld_shifted[7:0]};
            F3_HU:   rdata_ext = {16'd0, ld_shifted[15:0]};
            default: rdata_ext = ld_shifted;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the EXE/MEM op against a req/ack SRAM port.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning down.
module dmem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic        mem_we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [3:0]  dm_be_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wdata_o,
    input  logic        dm_ack_i,
    input  logic [31:0] dm_rdata_i,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        stall_o,
    output logic        bus_err_o,
    output logic        misalign_o
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    dm_req_t          req_q, req_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             berr_q, berr_d;
    logic             mis_q, mis_d;
    logic [2:0]       ld_f3_q, ld_f3_d;
    logic [1:0]       ld_off_q, ld_off_d;

    logic [3:0]  be_c;
    logic [31:0] wdata_rep_c;
    logic [31:0] rdata_ext_c;
    logic        misaligned_c;

    // Load side uses the op latched at issue so extraction is independent of live inputs.
    dmem_lsu_align u_align (
        .st_size    (funct3_i[1:0]),
        .st_off     (addr_i[1:0]),
        .wdata      (wdata_i),
        .ld_funct3  (ld_f3_q),
        .ld_off     (ld_off_q),
        .rdata      (dm_rdata_i),
        .be         (be_c),
        .wdata_rep  (wdata_rep_c),
        .rdata_ext  (rdata_ext_c),
        .misaligned (misaligned_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            req_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            berr_q   <= 1'b0;
            mis_q    <= 1'b0;
            ld_f3_q  <= '0;
            ld_off_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            req_q    <= req_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            berr_q   <= berr_d;
            mis_q    <= mis_d;
            ld_f3_q  <= ld_f3_d;
            ld_off_q <= ld_off_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        req_d    = req_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        berr_d   = 1'b0;
        mis_d    = 1'b0;
        ld_f3_d  = ld_f3_q;
        ld_off_d = ld_off_q;
        stall_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_valid_i) begin
                    stall_o = 1'b1;
                    if (TRAP_EN && misaligned_c) begin
                        state_d = DONE;
                        mis_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d       = ACCESS;
                        timer_d       = '0;
                        req_d.req     = 1'b1;
                        req_d.we      = mem_we_i;
                        req_d.be      = mem_we_i ? be_c : 4'b1111;
                        req_d.addr    = {addr_i[31:2], 2'b00};
                        req_d.wdata   = wdata_rep_c;
                        ld_f3_d       = funct3_i;
                        ld_off_d      = addr_i[1:0];
                    end
                end
            end
            ACCESS: begin
                stall_o = 1'b1;
                if (dm_ack_i) begin
                    state_d   = DONE;
                    req_d.req = 1'b0;
                    req_d.we  = 1'b0;
                    req_d.be  = '0;
                    if (!req_q.we) begin
                        rdata_d  = rdata_ext_c;
                        rvalid_d = 1'b1;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = DONE;
                    req_d.req = 1'b0;
                    req_d.we  = 1'b0;
                    req_d.be  = '0;
                    rdata_d   = '0;
                    berr_d    = 1'b1;
                end else begin
                    timer_d = TMR_W'(timer_q + 1'b1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign dm_req_o      = req_q.req;
    assign dm_we_o       = req_q.we;
    assign dm_be_o       = req_q.be;
    assign dm_addr_o     = req_q.addr;
    assign dm_wdata_o    = req_q.wdata;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q;
    assign bus_err_o     = berr_q;
    assign misalign_o    = mis_q;

endmodule
